// File: rtl/ahb_lite_slv_sif.sv
// rtl/ahb_lite_slv_sif.sv - AHB-Lite subordinate to single-beat dv/hld/err client bridge
// Optional size checking: define AHB_SLV_SIF_SIZE_ERR_EN.
module ahb_lite_slv_sif #(
    parameter int AHB_ADDR_WIDTH    = 32,
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int CLIENT_DATA_WIDTH = 32
) (
    input  logic                         hclk,
    input  logic                         hreset,
    input  logic [AHB_ADDR_WIDTH-1:0]    haddr_i,
    input  logic [2:0]                   hsize_i,
    input  logic [1:0]                   htrans_i,
    input  logic                         hwrite_i,
    input  logic [AHB_DATA_WIDTH-1:0]    hwdata_i,
    input  logic                         hsel_i,
    input  logic                         hready_i,
    output logic [AHB_DATA_WIDTH-1:0]    hrdata_o,
    output logic                         hresp_o,
    output logic                         hreadyout_o,
    output logic                         dv,
    input  logic                         hld,
    input  logic                         err,
    output logic                         write,
    output logic [CLIENT_DATA_WIDTH-1:0] wdata,
    output logic [AHB_ADDR_WIDTH-1:0]    addr,
    input  logic [CLIENT_DATA_WIDTH-1:0] rdata
);

    localparam int NLANES  = AHB_DATA_WIDTH / CLIENT_DATA_WIDTH;
    localparam int LANE_LO = $clog2(CLIENT_DATA_WIDTH / 8);
    localparam int LANE_W  = (NLANES > 1) ? $clog2(NLANES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR} state_t;

    state_t                    r_state;
    logic [AHB_ADDR_WIDTH-1:0] r_addr;
    logic                      r_write;
    logic                      r_szerr;

    logic              w_accept;
    logic              w_szerr_acc;
    logic              w_abort;
    logic              w_stall;
    logic              w_take;
    logic [LANE_W-1:0] w_lane;
    logic              w_unused;

`ifdef AHB_SLV_SIF_SIZE_ERR_EN
    assign w_szerr_acc = (hsize_i > 3'(LANE_LO));
    assign w_unused    = htrans_i[0];
`else
    assign w_szerr_acc = 1'b0;
    assign w_unused    = ^{htrans_i[0], hsize_i};
`endif

    assign w_accept = hsel_i & hready_i & htrans_i[1];
    // An oversized access turns its data cycle into ERROR cycle 1 without the client seeing it.
    assign w_abort  = (r_state == ST_DATA) & (r_szerr | err);
    assign w_stall  = (r_state == ST_DATA) & ~w_abort & hld;
    assign w_take   = w_accept & ~w_abort & ~w_stall;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_szerr <= 1'b0;
        end else begin
            if (w_take) begin
                r_addr  <= haddr_i;
                r_write <= hwrite_i;
                r_szerr <= w_szerr_acc;
            end
            case (r_state)
                ST_DATA: begin
                    if (w_abort)      r_state <= ST_ERR;
                    else if (w_stall) r_state <= ST_DATA;
                    else if (w_take)  r_state <= ST_DATA;
                    else              r_state <= ST_IDLE;
                end
                default: r_state <= w_take ? ST_DATA : ST_IDLE;
            endcase
        end
    end

    generate
        if (NLANES > 1) begin : g_lane
            assign w_lane = r_addr[LANE_LO +: LANE_W];
        end else begin : g_nolane
            assign w_lane = '0;
        end
    endgenerate

    always_comb begin
        wdata = hwdata_i[CLIENT_DATA_WIDTH-1:0];
        for (int i = 1; i < NLANES; i++) begin
            if (w_lane == LANE_W'(i)) wdata = hwdata_i[i*CLIENT_DATA_WIDTH +: CLIENT_DATA_WIDTH];
        end
    end

    assign dv          = (r_state == ST_DATA) & ~r_szerr;
    assign hresp_o     = (r_state == ST_ERR) | w_abort;
    assign hreadyout_o = ~(w_abort | w_stall);
    assign hrdata_o    = (r_state == ST_DATA) ? {NLANES{rdata}} : '0;
    assign write       = r_write;
    assign addr        = r_addr;

endmodule

// File: tb/tb_ahb_lite_slv_sif.sv
// tb/tb_ahb_lite_slv_sif.sv - directed scoreboard bench for ahb_lite_slv_sif
module tb_ahb_lite_slv_sif;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr_i;
    logic [2:0]  hsize_i;
    logic [1:0]  htrans_i;
    logic        hwrite_i;
    logic [63:0] hwdata_i;
    logic        hsel_i;
    logic [63:0] hrdata_o;
    logic        hresp_o;
    logic        hreadyout_o;
    logic        dv;
    logic        hld;
    logic        err;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [63:0] rd;
    } exp_t;

    exp_t exp_q[$];

    always #5 hclk = ~hclk;

    ahb_lite_slv_sif #(
        .AHB_ADDR_WIDTH(32),
        .AHB_DATA_WIDTH(64),
        .CLIENT_DATA_WIDTH(32)
    ) dut (
        .hclk(hclk),
        .hreset(hreset),
        .haddr_i(haddr_i),
        .hsize_i(hsize_i),
        .htrans_i(htrans_i),
        .hwrite_i(hwrite_i),
        .hwdata_i(hwdata_i),
        .hsel_i(hsel_i),
        .hready_i(hreadyout_o),
        .hrdata_o(hrdata_o),
        .hresp_o(hresp_o),
        .hreadyout_o(hreadyout_o),
        .dv(dv),
        .hld(hld),
        .err(err),
        .write(write),
        .wdata(wdata),
        .addr(addr),
        .rdata(rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge hclk);
        #1;
    endtask

    task automatic samp();
        @(negedge hclk);
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel_i   = 1'b1;
        htrans_i = 2'b10;
        hwrite_i = wr;
        haddr_i  = a;
        hsize_i  = sz;
    endtask

    task automatic bus_idle();
        hsel_i   = 1'b0;
        htrans_i = 2'b00;
    endtask

    // Completing client beats are popped against the scoreboard.
    always @(negedge hclk) begin
        if (!hreset && dv && hreadyout_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_write", 64'(write), 64'(e.wr));
                check("sb_addr", 64'(addr), 64'(e.addr));
                if (e.wr) check("sb_wdata", 64'(wdata), 64'(e.wdata));
                else      check("sb_hrdata", hrdata_o, e.rd);
            end
        end
    end

    initial begin
        hreset = 1'b1;
        bus_idle();
        hwrite_i = 1'b0; haddr_i = '0; hsize_i = 3'd2; hwdata_i = '0;
        hld = 1'b0; err = 1'b0; rdata = '0;

        repeat (2) next();
        samp();
        check("rst_dv", 64'(dv), 64'd0);
        check("rst_hready", 64'(hreadyout_o), 64'd1);
        check("rst_hresp", 64'(hresp_o), 64'd0);
        check("rst_hrdata", hrdata_o, 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_write", 64'(write), 64'd0);
        next();
        hreset = 1'b0;

        // Zero-wait write, upper lane
        next();
        addr_phase(1'b1, 32'h104, 3'd2);
        exp_q.push_back('{wr: 1'b1, addr: 32'h104, wdata: 32'hAAAABBBB, rd: 64'd0});
        samp();
        check("wr_addrph_dv", 64'(dv), 64'd0);
        next();
        bus_idle();
        hwdata_i = 64'hAAAABBBB_11112222;
        samp();
        check("wr_dv", 64'(dv), 64'd1);
        check("wr_hready", 64'(hreadyout_o), 64'd1);
        check("wr_hresp", 64'(hresp_o), 64'd0);
        next();
        samp();
        check("wr_after_dv", 64'(dv), 64'd0);

        // Read with two wait states
        next();
        addr_phase(1'b0, 32'h100, 3'd2);
        exp_q.push_back('{wr: 1'b0, addr: 32'h100, wdata: 32'd0, rd: 64'h12345678_12345678});
        next();
        bus_idle();
        rdata = 32'h12345678;
        hld = 1'b1;
        samp();
        check("rd_wait1_hready", 64'(hreadyout_o), 64'd0);
        check("rd_wait1_dv", 64'(dv), 64'd1);
        next();
        samp();
        check("rd_wait2_hready", 64'(hreadyout_o), 64'd0);
        check("rd_wait2_addr", 64'(addr), 64'h100);
        next();
        hld = 1'b0;
        samp();
        check("rd_done_hready", 64'(hreadyout_o), 64'd1);
        check("rd_done_hrdata", hrdata_o, 64'h12345678_12345678);
        next();
        rdata = '0;
        samp();
        check("rd_idle_hrdata", hrdata_o, 64'd0);

        // Read with client error
        next();
        addr_phase(1'b0, 32'h108, 3'd2);
        next();
        bus_idle();
        err = 1'b1;
        hld = 1'b1;
        samp();
        check("err1_dv", 64'(dv), 64'd1);
        check("err1_hresp", 64'(hresp_o), 64'd1);
        check("err1_hready", 64'(hreadyout_o), 64'd0);
        next();
        err = 1'b0;
        hld = 1'b0;
        samp();
        check("err2_dv", 64'(dv), 64'd0);
        check("err2_hresp", 64'(hresp_o), 64'd1);
        check("err2_hready", 64'(hreadyout_o), 64'd1);
        next();
        samp();
        check("err3_hresp", 64'(hresp_o), 64'd0);
        check("err3_hready", 64'(hreadyout_o), 64'd1);

        // Back-to-back pipelined writes
        next();
        addr_phase(1'b1, 32'h0, 3'd2);
        exp_q.push_back('{wr: 1'b1, addr: 32'h0, wdata: 32'hCAFEF00D, rd: 64'd0});
        next();
        addr_phase(1'b1, 32'h4, 3'd2);
        hwdata_i = 64'h00000000_CAFEF00D;
        exp_q.push_back('{wr: 1'b1, addr: 32'h4, wdata: 32'hDEADBEEF, rd: 64'd0});
        samp();
        check("b2b_0_dv", 64'(dv), 64'd1);
        check("b2b_0_hready", 64'(hreadyout_o), 64'd1);
        check("b2b_0_addr", 64'(addr), 64'h0);
        next();
        bus_idle();
        hwdata_i = 64'hDEADBEEF_00000000;
        samp();
        check("b2b_1_dv", 64'(dv), 64'd1);
        check("b2b_1_hready", 64'(hreadyout_o), 64'd1);
        check("b2b_1_addr", 64'(addr), 64'h4);
        next();
        samp();
        check("b2b_end_dv", 64'(dv), 64'd0);

        // Non-accepted transfers
        next();
        hsel_i = 1'b1; htrans_i = 2'b00; haddr_i = 32'h40;
        next();
        hsel_i = 1'b0; htrans_i = 2'b10; haddr_i = 32'h44;
        samp();
        check("idle_trans_dv", 64'(dv), 64'd0);
        check("idle_trans_hready", 64'(hreadyout_o), 64'd1);
        next();
        bus_idle();
        samp();
        check("nosel_dv", 64'(dv), 64'd0);
        check("nosel_hready", 64'(hreadyout_o), 64'd1);

        // Oversized access
        next();
        addr_phase(1'b1, 32'h0, 3'd3);
`ifndef AHB_SLV_SIF_SIZE_ERR_EN
        exp_q.push_back('{wr: 1'b1, addr: 32'h0, wdata: 32'h22222222, rd: 64'd0});
`endif
        next();
        bus_idle();
        hwdata_i = 64'h11111111_22222222;
        samp();
`ifdef AHB_SLV_SIF_SIZE_ERR_EN
        check("sz_dv", 64'(dv), 64'd0);
        check("sz_err1", 64'({hresp_o, hreadyout_o}), 64'b10);
        next();
        samp();
        check("sz_err2", 64'({hresp_o, hreadyout_o}), 64'b11);
        check("sz_err2_dv", 64'(dv), 64'd0);
`else
        check("sz_dv", 64'(dv), 64'd1);
        check("sz_resp", 64'({hresp_o, hreadyout_o}), 64'b01);
`endif
        next();
        samp();
        check("sz_end", 64'({dv, hresp_o, hreadyout_o}), 64'b001);

        // Reset during a stalled transfer
        next();
        addr_phase(1'b0, 32'h200, 3'd2);
        next();
        bus_idle();
        hld = 1'b1;
        samp();
        check("abort_pre_hready", 64'(hreadyout_o), 64'd0);
        next();
        hreset = 1'b1;
        #1;
        check("abort_dv", 64'(dv), 64'd0);
        check("abort_hready", 64'(hreadyout_o), 64'd1);
        check("abort_addr", 64'(addr), 64'd0);
        next();
        hreset = 1'b0;
        hld = 1'b0;
        repeat (2) next();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
